// File: rtl/exec_pkg.sv
// exec_pkg: shared constants for the execution core.
//   - XLEN / register-file geometry
//   - ALU opcode encodings (ALU_ADD .. ALU_PASSB; codes 11-31 yield 0)
//   - immediate format selects (IMM_I, IMM_S, IMM_B, IMM_U)
//   - bit positions inside the 4-bit status word (ST_Z, ST_N, ST_C, ST_V)
package exec_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SLL   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_SLT   = 5'd8;
    localparam logic [4:0] ALU_SLTU  = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_U = 2'b11;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

endpackage

// File: rtl/exec_if.sv
// exec_if: instruction/control/data bundle between the datapath controller
// and exec_core.
//   master (controller): drives instr, immsrc, regRW, ALUsrc, ALUop, dataIn;
//                        receives dataA, dataB, imm, aluOut, status.
//   slave  (exec_core):  the mirror image.
interface exec_if;
    import exec_pkg::*;

    logic [XLEN-1:0] instr;
    logic [1:0]      immsrc;
    logic            regRW;
    logic            ALUsrc;
    logic [4:0]      ALUop;
    logic [XLEN-1:0] dataIn;
    logic [XLEN-1:0] dataA;
    logic [XLEN-1:0] dataB;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] aluOut;
    logic [3:0]      status;

    modport master (
        output instr, immsrc, regRW, ALUsrc, ALUop, dataIn,
        input  dataA, dataB, imm, aluOut, status
    );

    modport slave (
        input  instr, immsrc, regRW, ALUsrc, ALUop, dataIn,
        output dataA, dataB, imm, aluOut, status
    );

endinterface

// File: rtl/exec_regfile.sv
// exec_regfile: 32 x 32 register file, one write port, two combinational
// read ports. x0 is hard-wired to zero; no write-through bypass, so a write
// is only visible after the clock edge.
//   clk, rst        : rising-edge clock, async active-high reset (clears all)
//   we/waddr/wdata  : write port, ignored for waddr==0 and while rst=1
//   ra/rdata_a      : read port A
//   rb/rdata_b      : read port B
// Optional: EXEC_TRACE_EN prints every committed write (simulation only).
module exec_regfile
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    output logic [XLEN-1:0]   rdata_a,
    output logic [XLEN-1:0]   rdata_b
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_commit;

    assign wr_commit = we && (waddr != '0);

    // regs[0] is cleared on reset and never written; reads of x0 are also
    // forced to zero below so it never depends on storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_commit) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (ra == '0) ? '0 : regs[ra];
    assign rdata_b = (rb == '0) ? '0 : regs[rb];

`ifdef EXEC_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && wr_commit)
            $display("x%0d <= 0x%08h", waddr, wdata);
    end
`endif

endmodule

// File: rtl/exec_core.sv
// exec_core: execution core of the single-cycle RISC-V datapath.
// Register file + immediate generator + 32-bit ALU; everything is
// combinational except the register writes.
//   clk  : rising-edge clock
//   rst  : async active-high reset, clears the register file
//   bus  : exec_if.slave
//          in : instr (rd=[11:7], rs1=[19:15], rs2=[24:20]), immsrc, regRW,
//               ALUsrc (1: B=dataB, 0: B=imm), ALUop, dataIn
//          out: dataA, dataB, imm, aluOut, status {V,C,N,Z}
// Optional: EXEC_TRACE_EN (see exec_regfile) traces register writes.
module exec_core
    import exec_pkg::*;
(
    input  logic clk,
    input  logic rst,
    exec_if.slave bus
);

    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] a, b, rs1_data, rs2_data, res;
    logic [XLEN:0]   sum, diff;
    logic            c, v;
    logic [3:0]      st;
    logic [4:0]      shamt;
    logic            unused_opcode;

    assign ins = bus.instr;
    // opcode bits are decoded by the controller, not here
    assign unused_opcode = ^ins[6:0];

    exec_regfile u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.regRW),
        .waddr   (ins[11:7]),
        .wdata   (bus.dataIn),
        .ra      (ins[19:15]),
        .rb      (ins[24:20]),
        .rdata_a (rs1_data),
        .rdata_b (rs2_data)
    );

    always_comb begin
        imm = '0;
        case (bus.immsrc)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            default: imm = '0;
        endcase
    end

    assign a     = rs1_data;
    assign b     = bus.ALUsrc ? rs2_data : imm;
    assign shamt = b[4:0];

    // One 33-bit adder each way: bit 32 of sum is carry-out, bit 32 of diff
    // is the borrow, so C on SUB is its inverse (A >= B unsigned).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (bus.ALUop)
            ALU_ADD: begin
                res = sum[XLEN-1:0];
                c   = sum[XLEN];
                v   = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                res = diff[XLEN-1:0];
                c   = ~diff[XLEN];
                v   = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND:   res = a & b;
            ALU_OR:    res = a | b;
            ALU_XOR:   res = a ^ b;
            ALU_SLL:   res = a << shamt;
            ALU_SRL:   res = a >> shamt;
            ALU_SRA:   res = $unsigned($signed(a) >>> shamt);
            ALU_SLT:   res = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  res = {31'b0, a < b};
            ALU_PASSB: res = b;
            default:   res = '0;
        endcase
    end

    always_comb begin
        st       = '0;
        st[ST_Z] = (res == '0);
        st[ST_N] = res[31];
        st[ST_C] = c;
        st[ST_V] = v;
    end

    assign bus.dataA  = rs1_data;
    assign bus.dataB  = rs2_data;
    assign bus.imm    = imm;
    assign bus.aluOut = res;
    assign bus.status = st;

endmodule

// File: tb/tb_exec_core.sv
module tb_exec_core;
    import exec_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    exec_if bus();

    exec_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  op;
        logic [31:0] res;
        logic [3:0]  st;   // {V,C,N,Z}
    } alu_vec_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [1:0]  sel;
        logic [31:0] imm;
    } imm_vec_t;

    alu_vec_t av [16];
    imm_vec_t iv [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
    endfunction

    task automatic wr(input logic [4:0] rd, input logic [31:0] val);
        @(negedge clk);
        bus.instr  = rtype(rd, 5'd0, 5'd0);
        bus.dataIn = val;
        bus.regRW  = 1'b1;
        @(negedge clk);
        bus.regRW  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        av[0]  = '{"add_ovf",   5'd1, 5'd2, ALU_ADD,   32'h8000_0000, 4'b1010};
        av[1]  = '{"add_carry", 5'd3, 5'd2, ALU_ADD,   32'h0000_0000, 4'b0101};
        av[2]  = '{"sub_eq",    5'd4, 5'd9, ALU_SUB,   32'h0000_0000, 4'b0101};
        av[3]  = '{"sub_lt",    5'd2, 5'd8, ALU_SUB,   32'hFFFF_FFFF, 4'b0010};
        av[4]  = '{"sra",       5'd6, 5'd7, ALU_SRA,   32'hF800_0000, 4'b0010};
        av[5]  = '{"slt",       5'd3, 5'd2, ALU_SLT,   32'h0000_0001, 4'b0000};
        av[6]  = '{"sltu",      5'd3, 5'd2, ALU_SLTU,  32'h0000_0000, 4'b0001};
        av[7]  = '{"undef20",   5'd1, 5'd2, 5'd20,     32'h0000_0000, 4'b0001};
        av[8]  = '{"and",       5'd1, 5'd3, ALU_AND,   32'h7FFF_FFFF, 4'b0000};
        av[9]  = '{"or",        5'd6, 5'd2, ALU_OR,    32'h8000_0001, 4'b0010};
        av[10] = '{"xor",       5'd3, 5'd1, ALU_XOR,   32'h8000_0000, 4'b0010};
        av[11] = '{"sll",       5'd2, 5'd7, ALU_SLL,   32'h0000_0010, 4'b0000};
        av[12] = '{"srl",       5'd6, 5'd7, ALU_SRL,   32'h0800_0000, 4'b0000};
        av[13] = '{"passb",     5'd1, 5'd6, ALU_PASSB, 32'h8000_0000, 4'b0010};
        // 0x7FFFFFFF - (-1): signed overflow, unsigned borrow
        av[14] = '{"sub_ovf",   5'd1, 5'd3, ALU_SUB,   32'h8000_0000, 4'b1010};
        // 0x80000000 - 1: signed overflow, no borrow
        av[15] = '{"sub_ovf2",  5'd6, 5'd2, ALU_SUB,   32'h7FFF_FFFF, 4'b1100};

        iv[0] = '{"imm_i_neg", 32'hFFF0_0093, IMM_I, 32'hFFFF_FFFF};
        iv[1] = '{"imm_i_pos", 32'h7FF0_0093, IMM_I, 32'h0000_07FF};
        iv[2] = '{"imm_b",     32'hFE00_0EE3, IMM_B, 32'hFFFF_FFFC}; // beq x0,x0,-4
        iv[3] = '{"imm_s",     32'h00A1_2423, IMM_S, 32'h0000_0008}; // sw x10,8(x2)
        iv[4] = '{"imm_u",     32'h1234_5037, IMM_U, 32'h1234_5000};

        bus.instr  = rtype(5'd0, 5'd5, 5'd5);
        bus.immsrc = IMM_I;
        bus.regRW  = 1'b0;
        bus.ALUsrc = 1'b1;
        bus.ALUop  = ALU_ADD;
        bus.dataIn = '0;
        rst        = 1'b1;

        // reset state
        #1;
        chk("reset_dataA", bus.dataA, 32'h0);
        chk("reset_dataB", bus.dataB, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // basic write / read
        wr(5'd5, 32'h0000_1234);
        bus.instr = rtype(5'd0, 5'd5, 5'd0);
        #1 chk("wr_x5_1234", bus.dataA, 32'h0000_1234);

        // same-cycle read sees old value, new value after the edge
        @(negedge clk);
        bus.instr  = rtype(5'd5, 5'd5, 5'd0);
        bus.dataIn = 32'hDEAD_BEEF;
        bus.regRW  = 1'b1;
        #1 chk("no_bypass", bus.dataA, 32'h0000_1234);
        @(negedge clk);
        bus.regRW  = 1'b0;
        chk("wr_x5_beef", bus.dataA, 32'hDEAD_BEEF);

        // writes to x0 are dropped
        wr(5'd0, 32'hCAFE_F00D);
        bus.instr = rtype(5'd0, 5'd0, 5'd0);
        #1 chk("x0_dataA", bus.dataA, 32'h0);
        chk("x0_dataB", bus.dataB, 32'h0);

        // async reset mid-cycle, then a write attempt under reset
        wr(5'd5, 32'h0000_1234);
        bus.instr = rtype(5'd0, 5'd5, 5'd5);
        #2 rst = 1'b1;
        #1 chk("rst_async_A", bus.dataA, 32'h0);
        chk("rst_async_B", bus.dataB, 32'h0);
        bus.instr  = rtype(5'd5, 5'd5, 5'd0);
        bus.dataIn = 32'h0000_0055;
        bus.regRW  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.regRW = 1'b0;
        rst       = 1'b0;
        #1 chk("rst_blocks_wr", bus.dataA, 32'h0);

        // operand registers for the ALU table
        wr(5'd1, 32'h7FFF_FFFF);
        wr(5'd2, 32'h0000_0001);
        wr(5'd3, 32'hFFFF_FFFF);
        wr(5'd4, 32'h0000_0010);
        wr(5'd6, 32'h8000_0000);
        wr(5'd7, 32'h0000_0004);
        wr(5'd8, 32'h0000_0002);
        wr(5'd9, 32'h0000_0010);

        bus.ALUsrc = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.instr = rtype(5'd0, av[k].rs1, av[k].rs2);
            bus.ALUop = av[k].op;
            #1;
            chk({av[k].name, "_res"}, bus.aluOut, av[k].res);
            chk({av[k].name, "_st"}, {28'h0, bus.status}, {28'h0, av[k].st});
        end

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.instr  = iv[k].instr;
            bus.immsrc = iv[k].sel;
            #1 chk(iv[k].name, bus.imm, iv[k].imm);
        end

        // addi x1,x1,5 : B comes from the immediate when ALUsrc=0
        @(negedge clk);
        bus.instr  = 32'h0050_8093;
        bus.immsrc = IMM_I;
        bus.ALUsrc = 1'b0;
        bus.ALUop  = ALU_ADD;
        #1 chk("addi_res", bus.aluOut, 32'h8000_0004);
        chk("addi_st", {28'h0, bus.status}, {28'h0, 4'b1010});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
